// File: rtl/key_scan_4x4.sv
// 4x4 matrix keypad scanner. It drives one active-low row at a time and
// samples the active-low columns at the end of each row dwell. The full
// 16-key map is debounced over whole scan frames, and a one-cycle key event
// is emitted for each clean single-key press.
module key_scan_4x4 #(
  parameter int unsigned SCAN_CYCLES = 999,
  parameter int unsigned DEB_FRAMES  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] key_map
);

  localparam int unsigned CW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEB_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_LOCK
  } state_t;

  logic [3:0]    r_col_s1;
  logic [3:0]    r_col_s2;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row;
  logic [15:0]   r_frame;
  logic [15:0]   r_prev;
  logic [DW-1:0] r_deb;
  logic [15:0]   r_key_map;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;
  state_t        r_state;

  logic          w_tick;
  logic          w_frame_end;
  logic [15:0]   w_frame;
  logic [DW-1:0] w_deb_nxt;
  state_t        w_state_nxt;
  logic          w_valid_nxt;
  logic          w_held_nxt;
  logic          w_load_code;
  logic          w_onehot;
  logic [3:0]    w_idx;

  assign w_tick      = (r_cnt == CW'(SCAN_CYCLES));
  assign w_frame_end = w_tick && (r_row_idx == 2'd3);

  // Frame with the current row's sample merged in, plus the next debounce count.
  always_comb begin
    w_frame = r_frame;
    w_frame[{r_row_idx, 2'b00} +: 4] = ~r_col_s2;
    if (w_frame == r_prev) begin
      w_deb_nxt = (r_deb == DW'(DEB_FRAMES - 1)) ? r_deb : r_deb + DW'(1);
    end else begin
      w_deb_nxt = '0;
    end
  end

  // Column synchronizer, row scan, frame assembly and debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_s1  <= '1;
      r_col_s2  <= '1;
      r_cnt     <= '0;
      r_row_idx <= '0;
      r_row     <= 4'b1110;
      r_frame   <= '0;
      r_prev    <= '0;
      r_deb     <= '0;
      r_key_map <= '0;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
      r_cnt    <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_frame   <= w_frame;
        r_row     <= {r_row[2:0], r_row[3]};
        r_row_idx <= r_row_idx + 2'd1;
      end
      if (w_frame_end) begin
        r_prev <= w_frame;
        r_deb  <= w_deb_nxt;
        if (w_deb_nxt == DW'(DEB_FRAMES - 1)) begin
          r_key_map <= w_frame;
        end
      end
    end
  end

  // One-hot test and index of the set bit in the debounced map.
  always_comb begin
    w_onehot = (r_key_map != '0) && ((r_key_map & (r_key_map - 16'd1)) == '0);
    w_idx    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (r_key_map[i]) begin
        w_idx = 4'(i);
      end
    end
  end

  // Key event FSM: next state and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;
    w_load_code = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_load_code = 1'b1;
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_state_nxt = S_PRESS;
        end else if (r_key_map != '0) begin
          w_state_nxt = S_LOCK;
        end
      end
      S_PRESS: begin
        if (r_key_map == '0) begin
          w_held_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_key_map != (16'd1 << r_key_code)) begin
          w_held_nxt  = 1'b0;
          w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        if (r_key_map == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and event output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
      if (w_load_code) begin
        r_key_code <= w_idx;
      end
    end
  end

  assign row       = r_row;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;
  assign key_map   = r_key_map;

endmodule

// File: tb/tb_key_scan_4x4.sv
// Bench for key_scan_4x4: a keypad model drives the columns from the
// pressed-key set, and a frame-level reference model predicts every output.
// Both are compared each cycle, with literal checks at key points.
module tb_key_scan_4x4;

  localparam int unsigned SCAN = 3;
  localparam int unsigned DEB  = 3;
  localparam int unsigned FRM  = 4 * (SCAN + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] key_map;

  logic [15:0] pressed;
  logic        col_ovr_en;
  logic [3:0]  col_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int base;

  key_scan_4x4 #(.SCAN_CYCLES(SCAN), .DEB_FRAMES(DEB)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .key_valid(key_valid), .key_code(key_code),
    .key_held(key_held), .key_map(key_map)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    if (col_ovr_en) begin
      col = col_ovr;
    end else begin
      for (int unsigned r = 0; r < 4; r++)
        for (int unsigned c = 0; c < 4; c++)
          if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The row sample uses the key set seen two clocks earlier.
  // Debouncing accepts a frame when the last DEB frames (with a virtual all-zero
  // frame after reset) are identical.
  bit          m_init = 0;
  int          m_k;
  int          m_mode;
  logic [15:0] m_c1, m_c2, m_frame, m_map;
  logic [15:0] m_hist[$];
  logic [3:0]  m_row, m_code;
  logic        m_valid, m_held;

  always @(posedge clk) begin
    logic [15:0] one16;
    logic [3:0]  one4;
    int          r;
    bit          same;
    one16 = 16'd1;
    one4  = 4'd1;
    if (rst) begin
      m_init = 1; m_k = 0; m_mode = 0;
      m_c1 = '0; m_c2 = '0; m_frame = '0; m_map = '0;
      m_hist = {16'h0000};
      m_row = 4'b1110; m_code = '0; m_valid = 0; m_held = 0;
    end else if (m_init) begin
      m_valid = 0;
      if (m_mode == 0) begin
        if ($countones(m_map) == 1) begin
          for (int i = 0; i < 16; i++) if (m_map[i]) m_code = 4'(i);
          m_valid = 1; m_held = 1; m_mode = 1;
        end else if ($countones(m_map) >= 2) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (m_map == 0) begin
          m_held = 0; m_mode = 0;
        end else if (m_map != (one16 << m_code)) begin
          m_held = 0; m_mode = 2;
        end
      end else begin
        if (m_map == 0) m_mode = 0;
      end
      if (m_k % 4 == 3) begin
        r = (m_k / 4) % 4;
        for (int c = 0; c < 4; c++) m_frame[r*4+c] = m_c2[r*4+c];
        if (r == 3) begin
          m_hist.push_back(m_frame);
          if (m_hist.size() > DEB) void'(m_hist.pop_front());
          same = (m_hist.size() == DEB);
          foreach (m_hist[j]) if (m_hist[j] != m_frame) same = 0;
          if (same) m_map = m_frame;
        end
      end
      m_c2 = m_c1;
      m_c1 = pressed;
      m_k++;
      m_row = ~(one4 << ((m_k / 4) % 4));
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("row",       32'(row),       32'(m_row));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_code",  32'(key_code),  32'(m_code));
      check("key_held",  32'(key_held),  32'(m_held));
      check("key_map",   32'(key_map),   32'(m_map));
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pressed = '0; col_ovr_en = 1'b1; col_ovr = 4'b1011;
    wait_cycles(2);
    check("rst_row", 32'(row), 32'h0000000E);
    check("rst_map", 32'(key_map), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    rst = 1'b0; col_ovr_en = 1'b0;
    wait_cycles(3);
    check("scan_row0", 32'(row), 32'h0000000E);
    wait_cycles(1);
    check("scan_row1", 32'(row), 32'h0000000D);
    wait_cycles(4 * FRM);

    // Clean press of key 6 (row 1, col 2)
    base = pulse_cnt;
    pressed = 16'h0040;
    wait_cycles(10 * FRM);
    check("press6_pulses", 32'(pulse_cnt - base), 32'd1);
    check("press6_code", 32'(key_code), 32'd6);
    check("press6_map", 32'(key_map), 32'h0040);
    check("press6_held", 32'(key_held), 32'd1);
    pressed = '0;
    wait_cycles(5 * FRM);
    check("release6_map", 32'(key_map), 32'h0);
    check("release6_held", 32'(key_held), 32'd0);

    // Bounce every frame
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = pressed ^ 16'h0040;
      wait_cycles(FRM);
    end
    pressed = '0;
    wait_cycles(5 * FRM);
    check("bounce_pulses", 32'(pulse_cnt - base), 32'd0);
    check("bounce_map", 32'(key_map), 32'h0);

    // Two keys together
    base = pulse_cnt;
    pressed = 16'h8001;
    wait_cycles(6 * FRM);
    check("two_map", 32'(key_map), 32'h8001);
    check("two_pulses", 32'(pulse_cnt - base), 32'd0);
    check("two_held", 32'(key_held), 32'd0);
    pressed = 16'h0001;
    wait_cycles(6 * FRM);
    check("lock_map", 32'(key_map), 32'h0001);
    check("lock_pulses", 32'(pulse_cnt - base), 32'd0);
    pressed = '0;
    wait_cycles(5 * FRM);

    // Press-hold-add
    base = pulse_cnt;
    pressed = 16'h0200;
    wait_cycles(6 * FRM);
    check("press9_pulses", 32'(pulse_cnt - base), 32'd1);
    check("press9_code", 32'(key_code), 32'd9);
    check("press9_held", 32'(key_held), 32'd1);
    base = pulse_cnt;
    pressed = 16'h0208;
    wait_cycles(6 * FRM);
    check("add3_held", 32'(key_held), 32'd0);
    check("add3_pulses", 32'(pulse_cnt - base), 32'd0);
    check("add3_code", 32'(key_code), 32'd9);
    check("add3_map", 32'(key_map), 32'h0208);
    pressed = '0;
    wait_cycles(5 * FRM);
    base = pulse_cnt;
    pressed = 16'h0008;
    wait_cycles(6 * FRM);
    check("press3_pulses", 32'(pulse_cnt - base), 32'd1);
    check("press3_code", 32'(key_code), 32'd3);
    pressed = '0;
    wait_cycles(5 * FRM);

    // Reset mid-debounce with key 5 held
    pressed = 16'h0020;
    wait_cycles(2 * FRM);
    rst = 1'b1;
    wait_cycles(2);
    check("mid_rst_row", 32'(row), 32'h0000000E);
    check("mid_rst_map", 32'(key_map), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    base = pulse_cnt;
    wait_cycles(3 * FRM);
    check("post_rst_map", 32'(key_map), 32'h0020);
    check("post_rst_early", 32'(pulse_cnt - base), 32'd0);
    wait_cycles(4);
    check("post_rst_pulses", 32'(pulse_cnt - base), 32'd1);
    check("post_rst_code", 32'(key_code), 32'd5);
    pressed = '0;
    wait_cycles(5 * FRM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
